// File: rtl/msdap_pkg.sv
// rtl/msdap_pkg.sv - shared types for the MSDAP output serializer
// Purpose: result word width, left/right pair type and serializer state encoding.
// Ports: none (package).
package msdap_pkg;

  localparam int OUT_W = 40;

  typedef logic [OUT_W-1:0] out_word_t;

  typedef struct packed {
    out_word_t L;
    out_word_t R;
  } out_pair_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } ser_state_e;

endpackage

// File: rtl/msdap_out_serializer_if.sv
// rtl/msdap_out_serializer_if.sv - result input handshake and serial output bundle
// Purpose: groups the parallel result handshake and the framed serial outputs.
// Ports: in_valid/in_dataL/in_dataR (producer -> serializer), in_ready (serializer -> producer),
//        OutputL/OutputR/OutReady (serializer -> receiver).
// Modports: master = serializer side, slave = producer/receiver side.
interface msdap_out_serializer_if;
  import msdap_pkg::*;

  logic      in_valid;
  logic      in_ready;
  out_word_t in_dataL;
  out_word_t in_dataR;
  logic      OutputL;
  logic      OutputR;
  logic      OutReady;

  modport master (
    input  in_valid, in_dataL, in_dataR,
    output in_ready, OutputL, OutputR, OutReady
  );

  modport slave (
    output in_valid, in_dataL, in_dataR,
    input  in_ready, OutputL, OutputR, OutReady
  );

endinterface

// File: rtl/msdap_out_fifo.sv
// rtl/msdap_out_fifo.sv - two-entry FIFO of result pairs
// Purpose: absorbs burst alignment between the accumulator and the serializer.
// Ports: clk, rst_n (async active-low), clr (sync clear), push/wdata, pop/rdata, full, empty.
module msdap_out_fifo
  import msdap_pkg::*;
#(
  parameter type T = out_pair_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  T           mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] cnt_q;
  logic       do_push;
  logic       do_pop;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (clr) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      // Simultaneous push and pop leaves the count unchanged.
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/msdap_out_serializer.sv
// rtl/msdap_out_serializer.sv - MSB-first left/right result serializer framed by OutReady
// Purpose: buffers result pairs and shifts each out one bit per SCLK with a minimum idle gap.
// Ports: SCLK, Reset_n (async active-low), flush (sync abort), sif (master: result handshake
//        and serial outputs), busy (FSM active or buffer non-empty).
module msdap_out_serializer
  import msdap_pkg::*;
#(
  parameter int MIN_GAP = 1
) (
  input  logic                          SCLK,
  input  logic                          Reset_n,
  input  logic                          flush,
  msdap_out_serializer_if.master        sif,
  output logic                          busy
);

  ser_state_e state_q, state_d;
  out_word_t  sh_l_q, sh_l_d;
  out_word_t  sh_r_q, sh_r_d;
  logic [5:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic       out_l_q, out_l_d;
  logic       out_r_q, out_r_d;
  logic       rdy_q, rdy_d;

  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  out_pair_t  fifo_wdata;
  out_pair_t  fifo_rdata;

  // Full blocks input even when a pop happens in the same cycle.
  assign sif.in_ready = !fifo_full && !flush;
  assign fifo_wdata   = '{L: sif.in_dataL, R: sif.in_dataR};
  assign busy         = (state_q != IDLE) || !fifo_empty;

  assign sif.OutputL  = out_l_q;
  assign sif.OutputR  = out_r_q;
  assign sif.OutReady = rdy_q;

  msdap_out_fifo #(.T(out_pair_t)) u_fifo (
    .clk   (SCLK),
    .rst_n (Reset_n),
    .clr   (flush),
    .push  (sif.in_valid && sif.in_ready),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Serial outputs default to 0 so they are forced low whenever OutReady is low.
  always_comb begin
    state_d   = state_q;
    sh_l_d    = sh_l_q;
    sh_r_d    = sh_r_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    out_l_d   = 1'b0;
    out_r_d   = 1'b0;
    rdy_d     = 1'b0;
    pop       = 1'b0;
    if (flush) begin
      state_d   = IDLE;
      sh_l_d    = '0;
      sh_r_d    = '0;
      bit_cnt_d = '0;
      gap_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            sh_l_d    = fifo_rdata.L;
            sh_r_d    = fifo_rdata.R;
            bit_cnt_d = 6'(OUT_W - 1);
            out_l_d   = fifo_rdata.L[OUT_W-1];
            out_r_d   = fifo_rdata.R[OUT_W-1];
            rdy_d     = 1'b1;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt_q == 6'd0) begin
            gap_cnt_d = 4'(MIN_GAP - 1);
            state_d   = GAP;
          end else begin
            sh_l_d    = {sh_l_q[OUT_W-2:0], 1'b0};
            sh_r_d    = {sh_r_q[OUT_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 6'd1;
            out_l_d   = sh_l_q[OUT_W-2];
            out_r_d   = sh_r_q[OUT_W-2];
            rdy_d     = 1'b1;
          end
        end
        GAP: begin
          // Always passes through IDLE, so the next word starts one edge later.
          if (gap_cnt_q == 4'd0) state_d = IDLE;
          else                   gap_cnt_d = gap_cnt_q - 4'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge SCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      sh_l_q    <= '0;
      sh_r_q    <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      out_l_q   <= 1'b0;
      out_r_q   <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_l_q    <= sh_l_d;
      sh_r_q    <= sh_r_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
      rdy_q     <= rdy_d;
    end
  end

endmodule

// File: tb/tb_msdap_out_serializer.sv
// tb/tb_msdap_out_serializer.sv - self-checking bench for msdap_out_serializer
module tb_msdap_out_serializer;
  import msdap_pkg::*;

  localparam int G1 = 1;
  localparam int G5 = 5;

  logic SCLK    = 1'b0;
  logic Reset_n = 1'b1;
  logic flush   = 1'b0;
  logic flush5  = 1'b0;
  logic busy;
  logic busy5;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int zero_viol = 0;

  typedef struct {
    out_word_t l;
    out_word_t r;
    int        len;
    int        rise;
    int        gap;
  } frame_t;

  frame_t frames[$];

  msdap_out_serializer_if sif ();
  msdap_out_serializer_if sif5 ();

  msdap_out_serializer #(.MIN_GAP(G1)) dut (
    .SCLK(SCLK), .Reset_n(Reset_n), .flush(flush), .sif(sif), .busy(busy)
  );

  msdap_out_serializer #(.MIN_GAP(G5)) dut5 (
    .SCLK(SCLK), .Reset_n(Reset_n), .flush(flush5), .sif(sif5), .busy(busy5)
  );

  always #25 SCLK = ~SCLK;
  always @(posedge SCLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Receiver model: collects each OutReady burst as one frame, with its rise edge and
  // the number of low cycles preceding it.
  initial begin
    bit        prev_rdy;
    bit        seen_fall;
    int        low_run;
    frame_t    cur;
    prev_rdy  = 1'b0;
    seen_fall = 1'b0;
    low_run   = 0;
    cur       = '{l: '0, r: '0, len: 0, rise: 0, gap: -1};
    forever begin
      @(negedge SCLK);
      if (sif.OutReady === 1'b1) begin
        if (!prev_rdy) begin
          cur.rise = cyc;
          cur.gap  = seen_fall ? low_run : -1;
          cur.len  = 0;
          cur.l    = '0;
          cur.r    = '0;
        end
        cur.l   = {cur.l[OUT_W-2:0], sif.OutputL};
        cur.r   = {cur.r[OUT_W-2:0], sif.OutputR};
        cur.len = cur.len + 1;
        prev_rdy = 1'b1;
      end else begin
        if (sif.OutputL !== 1'b0 || sif.OutputR !== 1'b0) zero_viol++;
        if (prev_rdy) begin
          frames.push_back(cur);
          seen_fall = 1'b1;
          low_run   = 0;
        end
        low_run++;
        prev_rdy = 1'b0;
      end
    end
  end

  function automatic out_word_t rnd_word();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[OUT_W-1:0];
  endfunction

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge SCLK);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle got busy=%0b exp=0", nm, busy);
    end
  endtask

  task automatic test_reset();
    sif.in_valid = 1'b0; sif.in_dataL = '0; sif.in_dataR = '0;
    sif5.in_valid = 1'b0; sif5.in_dataL = '0; sif5.in_dataR = '0;
    flush = 1'b0;
    Reset_n = 1'b0;
    repeat (3) @(negedge SCLK);
    Reset_n = 1'b1;
    @(negedge SCLK);
    checks++; if (sif.OutReady !== 1'b0) begin errors++; $display("FAIL reset_OutReady got=%b exp=0", sif.OutReady); end
    checks++; if (sif.OutputL !== 1'b0) begin errors++; $display("FAIL reset_OutputL got=%b exp=0", sif.OutputL); end
    checks++; if (sif.OutputR !== 1'b0) begin errors++; $display("FAIL reset_OutputR got=%b exp=0", sif.OutputR); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", sif.in_ready); end
    checks++; if (sif5.OutReady !== 1'b0) begin errors++; $display("FAIL reset_OutReady5 got=%b exp=0", sif5.OutReady); end
    flush = 1'b1;
    #1;
    checks++; if (sif.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", sif.in_ready); end
    @(negedge SCLK);
    flush = 1'b0;
    #1;
    checks++; if (sif.in_ready !== 1'b1) begin errors++; $display("FAIL post_flush_in_ready got=%b exp=1", sif.in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_flush_busy got=%b exp=0", busy); end
  endtask

  // Push one pair into an idle block and follow it bit by bit.
  task automatic test_single(input out_word_t l, input out_word_t r, input string nm);
    int bad_rdy = 0;
    int bad_l   = 0;
    int bad_r   = 0;
    sif.in_valid = 1'b1; sif.in_dataL = l; sif.in_dataR = r;
    #1;
    checks++; if (sif.in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready got=%b exp=1", nm, sif.in_ready); end
    @(negedge SCLK);
    sif.in_valid = 1'b0;
    checks++; if (sif.OutReady !== 1'b0) begin errors++; $display("FAIL %s_early got=%b exp=0", nm, sif.OutReady); end
    for (int k = 1; k <= OUT_W; k++) begin
      @(negedge SCLK);
      if (sif.OutReady !== 1'b1) bad_rdy++;
      if (sif.OutputL !== l[OUT_W-k]) bad_l++;
      if (sif.OutputR !== r[OUT_W-k]) bad_r++;
    end
    checks++; if (bad_rdy != 0) begin errors++; $display("FAIL %s_frame got=%0d low cycles exp=0", nm, bad_rdy); end
    checks++; if (bad_l != 0) begin errors++; $display("FAIL %s_L got=%0d bad bits exp=0", nm, bad_l); end
    checks++; if (bad_r != 0) begin errors++; $display("FAIL %s_R got=%0d bad bits exp=0", nm, bad_r); end
    @(negedge SCLK);
    checks++;
    if (sif.OutReady !== 1'b0 || sif.OutputL !== 1'b0 || sif.OutputR !== 1'b0) begin
      errors++;
      $display("FAIL %s_end got=%b%b%b exp=000", nm, sif.OutReady, sif.OutputL, sif.OutputR);
    end
    wait_idle(nm);
  endtask

  // Timeline model: each word starts one edge after acceptance or one full period after
  // the previous start, whichever is later; occupancy = accepted - started.
  task automatic test_back_to_back();
    out_pair_t pairs[4];
    int acc[4];
    int st[4];
    int n_acc = 0;
    int base;
    int cnt;
    bit exp_rdy;
    for (int i = 0; i < 4; i++) begin
      pairs[i].L = rnd_word();
      pairs[i].R = rnd_word();
    end
    base = frames.size();
    for (int c = 0; c < 400 && n_acc < 4; c++) begin
      cnt = 0;
      for (int k = 0; k < n_acc; k++) begin
        if (acc[k] <= cyc) cnt++;
        if (st[k] <= cyc) cnt--;
      end
      exp_rdy = (cnt < 2);
      sif.in_valid = 1'b1; sif.in_dataL = pairs[n_acc].L; sif.in_dataR = pairs[n_acc].R;
      #1;
      checks++;
      if (sif.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL b2b_in_ready word=%0d got=%b exp=%b", n_acc, sif.in_ready, exp_rdy);
      end
      if (exp_rdy) begin
        acc[n_acc] = cyc + 1;
        if (n_acc == 0) st[n_acc] = acc[n_acc] + 1;
        else if (acc[n_acc] + 1 > st[n_acc-1] + OUT_W + G1 + 1) st[n_acc] = acc[n_acc] + 1;
        else st[n_acc] = st[n_acc-1] + OUT_W + G1 + 1;
        n_acc++;
      end
      @(negedge SCLK);
    end
    sif.in_valid = 1'b0;
    for (int c = 0; c < 400 && frames.size() < base + 4; c++) @(negedge SCLK);
    checks++;
    if (frames.size() < base + 4) begin
      errors++;
      $display("FAIL b2b_frames got=%0d exp=4", frames.size() - base);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (frames[base+k].l !== pairs[k].L || frames[base+k].r !== pairs[k].R) begin
          errors++;
          $display("FAIL b2b_data word=%0d got=%h/%h exp=%h/%h", k,
                   frames[base+k].l, frames[base+k].r, pairs[k].L, pairs[k].R);
        end
        checks++;
        if (frames[base+k].len != OUT_W) begin
          errors++; $display("FAIL b2b_len word=%0d got=%0d exp=%0d", k, frames[base+k].len, OUT_W);
        end
        checks++;
        if (frames[base+k].rise != st[k]) begin
          errors++; $display("FAIL b2b_start word=%0d got=%0d exp=%0d", k, frames[base+k].rise, st[k]);
        end
        if (k > 0) begin
          checks++;
          if (frames[base+k].gap != G1 + 1) begin
            errors++; $display("FAIL b2b_gap word=%0d got=%0d exp=%0d", k, frames[base+k].gap, G1 + 1);
          end
        end
      end
    end
    wait_idle("b2b");
  endtask

  task automatic test_gap();
    out_pair_t a;
    out_pair_t b;
    int        rises = 0;
    int        lows  = 0;
    int        len[2];
    out_word_t wl[2];
    out_word_t wr[2];
    bit        prev = 1'b0;
    bit        done = 1'b0;
    len[0] = 0; len[1] = 0; wl[0] = '0; wl[1] = '0; wr[0] = '0; wr[1] = '0;
    a.L = rnd_word(); a.R = rnd_word();
    b.L = rnd_word(); b.R = rnd_word();
    sif5.in_valid = 1'b1; sif5.in_dataL = a.L; sif5.in_dataR = a.R;
    #1;
    checks++; if (sif5.in_ready !== 1'b1) begin errors++; $display("FAIL gap_push0 got=%b exp=1", sif5.in_ready); end
    @(negedge SCLK);
    sif5.in_dataL = b.L; sif5.in_dataR = b.R;
    #1;
    checks++; if (sif5.in_ready !== 1'b1) begin errors++; $display("FAIL gap_push1 got=%b exp=1", sif5.in_ready); end
    @(negedge SCLK);
    sif5.in_valid = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (sif5.OutReady === 1'b1) begin
        if (!prev) rises++;
        if (rises <= 2) begin
          len[rises-1]++;
          wl[rises-1] = {wl[rises-1][OUT_W-2:0], sif5.OutputL};
          wr[rises-1] = {wr[rises-1][OUT_W-2:0], sif5.OutputR};
        end
        prev = 1'b1;
      end else begin
        if (rises == 1) lows++;
        if (rises == 2 && prev) done = 1'b1;
        prev = 1'b0;
      end
      @(negedge SCLK);
    end
    checks++; if (lows != G5 + 1) begin errors++; $display("FAIL gap_low_cycles got=%0d exp=%0d", lows, G5 + 1); end
    checks++;
    if (len[0] != OUT_W || len[1] != OUT_W) begin
      errors++; $display("FAIL gap_len got=%0d,%0d exp=%0d", len[0], len[1], OUT_W);
    end
    checks++;
    if (wl[0] !== a.L || wr[0] !== a.R || wl[1] !== b.L || wr[1] !== b.R) begin
      errors++; $display("FAIL gap_data got=%h,%h exp=%h,%h", wl[0], wl[1], a.L, b.L);
    end
  endtask

  task automatic test_flush();
    int stray = 0;
    sif.in_valid = 1'b1; sif.in_dataL = rnd_word(); sif.in_dataR = rnd_word();
    @(negedge SCLK);
    sif.in_dataL = rnd_word(); sif.in_dataR = rnd_word();
    @(negedge SCLK);
    sif.in_valid = 1'b0;
    repeat (19) @(negedge SCLK);
    checks++; if (sif.OutReady !== 1'b1) begin errors++; $display("FAIL flush_midword got=%b exp=1", sif.OutReady); end
    flush = 1'b1;
    sif.in_valid = 1'b1;
    #1;
    checks++; if (sif.in_ready !== 1'b0) begin errors++; $display("FAIL flush_cycle_ready got=%b exp=0", sif.in_ready); end
    @(negedge SCLK);
    flush = 1'b0;
    sif.in_valid = 1'b0;
    checks++; if (sif.OutReady !== 1'b0) begin errors++; $display("FAIL flush_OutReady got=%b exp=0", sif.OutReady); end
    checks++; if (sif.OutputL !== 1'b0) begin errors++; $display("FAIL flush_OutputL got=%b exp=0", sif.OutputL); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
    repeat (10) begin
      @(negedge SCLK);
      if (sif.OutReady !== 1'b0) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL flush_stray got=%0d exp=0", stray); end
    test_single(rnd_word(), rnd_word(), "after_flush");
  endtask

  task automatic test_async_reset();
    int stray = 0;
    sif.in_valid = 1'b1; sif.in_dataL = rnd_word(); sif.in_dataR = rnd_word();
    @(negedge SCLK);
    sif.in_valid = 1'b0;
    repeat (10) @(negedge SCLK);
    checks++; if (sif.OutReady !== 1'b1) begin errors++; $display("FAIL areset_midword got=%b exp=1", sif.OutReady); end
    @(posedge SCLK);
    #5 Reset_n = 1'b0;
    #1;
    checks++;
    if (sif.OutReady !== 1'b0 || sif.OutputL !== 1'b0 || sif.OutputR !== 1'b0) begin
      errors++;
      $display("FAIL areset_outputs got=%b%b%b exp=000", sif.OutReady, sif.OutputL, sif.OutputR);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", busy); end
    #39 Reset_n = 1'b1;
    repeat (50) begin
      @(negedge SCLK);
      if (sif.OutReady !== 1'b0) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL areset_stray got=%0d exp=0", stray); end
    test_single(rnd_word(), rnd_word(), "after_areset");
  endtask

  initial begin
    test_reset();
    test_single(40'h80_0000_0001, 40'h7F_FFFF_FFFE, "single_spec");
    for (int i = 0; i < 3; i++) test_single(rnd_word(), rnd_word(), "single_rand");
    test_back_to_back();
    test_gap();
    test_flush();
    test_async_reset();
    checks++;
    if (zero_viol != 0) begin errors++; $display("FAIL idle_zero got=%0d exp=0", zero_viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
